alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CTL_W, 4, ALU control width; SHALL equal the ALU32Bit ALUControl width.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 ReqNValid  input  1  request present on port N (N=0,1).
REQ-005 ReqNReady  output  1  arbiter accepts port N request this cycle.
REQ-006 ReqNCtl  input  CTL_W  ALU operation code for port N.
REQ-007 ReqNA, ReqNB  input  32  operands for port N.
REQ-008 RspNValid  output  1  result available for port N.
REQ-009 RspNReady  input  1  port N consumes result.
REQ-010 RspResult  output  32  registered ALU result, shared by both ports.
REQ-011 RspZero  output  1  registered ALU Zero flag, shared by both ports.
REQ-012 ALUControl  output  CTL_W  to ALU control input.
REQ-013 ALUA, ALUB  output  32  to ALU operand inputs.
REQ-014 ALUResult  input  32  from ALU result.
REQ-015 ALUZero  input  1  from ALU Zero.
REQ-016 Busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-018 IDLE: grant is combinational from ReqNValid and the priority pointer; only the granted port SHALL see ReqNReady=1; ReqNReady SHALL be 0 in EXEC and RESP.
REQ-019 Grant with one valid port: that port, regardless of pointer; both valid: the port selected by the pointer; neither valid: no grant, stay IDLE.
REQ-020 On ReqNValid&&ReqNReady, the block SHALL latch Ctl, A, B and owner index into operand registers and move to EXEC.
REQ-021 ALUControl/ALUA/ALUB SHALL be driven from the operand registers at all times (stable through EXEC).
REQ-022 EXEC lasts exactly one cycle; at its end ALUResult and ALUZero SHALL be captured into RspResult/RspZero, then go to RESP.
REQ-023 RESP: only the owner's RspNValid SHALL be 1; state holds and RspResult/RspZero SHALL stay stable until the owner's RspNReady=1, then return to IDLE.
REQ-024 Latency: accept in cycle T -> RspNValid high in cycle T+2; minimum issue interval 3 cycles.
REQ-025 RspNReady from the non-owner, and RspNReady outside RESP, SHALL be ignored.
REQ-026 The block SHALL NOT decode ALUControl; every code, including unused codes (ALU returns 0) and 14 (ALU returns all ones), passes through unchanged.
REQ-027 RspZero SHALL be the captured ALUZero, never recomputed.
REQ-028 Requesters SHALL hold Valid and payload until Ready; the block does not check this.

Reset
REQ-029 Reset SHALL force state IDLE, pointer to port 0, operand registers, RspResult and RspZero to 0, and all RspNValid and ReqNReady low (Busy=0).
REQ-030 Reset during EXEC or RESP SHALL abort the operation; no response SHALL be delivered for it.

Configuration
REQ-031 With ALU_ARB_RR_EN defined: round-robin; after each accept the pointer SHALL point to the other port.
REQ-032 Without ALU_ARB_RR_EN: fixed priority, port 0 SHALL win when both are valid; no pointer register SHALL exist.

Verification
REQ-033 Port0 Ctl=2, A=5, B=7 -> Req0Ready high in cycle T; Rsp0Valid in cycle T+2 with RspResult=12, RspZero=0; Rsp1Valid stays 0.
REQ-034 Port1 Ctl=6, A=9, B=9 -> RspResult=0, RspZero=1 on Rsp1Valid.
REQ-035 Both ports valid continuously, RR build -> grants alternate 0,1,0,1; fixed build -> port 0 is granted every time.
REQ-036 Rsp0Ready held low 5 cycles in RESP -> Rsp0Valid and RspResult stable for 5 cycles, Busy=1, Req1Ready=0 throughout.
REQ-037 Reset asserted during EXEC of Ctl=15, A=3, B=4 -> next cycle IDLE, Busy=0, RspResult=0, no RspNValid pulse.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters.
//   One operation is in flight at a time. The arbiter grants a port in IDLE,
//   latches the operands, and spends one cycle in EXEC while the ALU settles.
//   It then captures the ALU result and holds it in RESP until the owning port
//   takes it.
//
//   Build option:
//     ALU_ARB_RR_EN  defined   -> round-robin between the two ports
//                    undefined -> fixed priority, port 0 wins
//
// Ports
//   Clk_i, Reset_i             clock; asynchronous active-high reset
//   ReqN{Valid_i,Ready_o}      request handshake for port N (N=0,1)
//   ReqNCtl_i, ReqNA_i, ReqNB_i
//                              ALU operation code and operands for port N
//   RspNValid_o, RspNReady_i   response handshake for port N
//   RspResult_o, RspZero_o     registered ALU result and Zero flag,
//                              shared by both ports
//   ALUControl_o, ALUA_o, ALUB_o
//                              drive the ALU from the operand registers
//   ALUResult_i, ALUZero_i     outputs returned by the ALU
//   Busy_o                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CTL_W = 4
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Req0Valid_i,
    output logic             Req0Ready_o,
    input  logic [CTL_W-1:0] Req0Ctl_i,
    input  logic [31:0]      Req0A_i,
    input  logic [31:0]      Req0B_i,
    input  logic             Req1Valid_i,
    output logic             Req1Ready_o,
    input  logic [CTL_W-1:0] Req1Ctl_i,
    input  logic [31:0]      Req1A_i,
    input  logic [31:0]      Req1B_i,
    output logic             Rsp0Valid_o,
    input  logic             Rsp0Ready_i,
    output logic             Rsp1Valid_o,
    input  logic             Rsp1Ready_i,
    output logic [31:0]      RspResult_o,
    output logic             RspZero_o,
    output logic [CTL_W-1:0] ALUControl_o,
    output logic [31:0]      ALUA_o,
    output logic [31:0]      ALUB_o,
    input  logic [31:0]      ALUResult_i,
    input  logic             ALUZero_i,
    output logic             Busy_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               owner_q;
    logic [CTL_W-1:0]   ctl_q;
    logic [31:0]        a_q, b_q;
    logic [31:0]        result_q;
    logic               zero_q;

    logic               prefer1;
    logic               gnt0, gnt1;
    logic               accept;
    logic               owner_rdy;

`ifdef ALU_ARB_RR_EN
    // Pointer = port that wins when both ports request at the same time.
    logic ptr_q;
    assign prefer1 = ptr_q;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            // Point to the port that was not served.
            ptr_q <= ~gnt1;
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    // If only one port is valid, it wins regardless of the pointer.
    assign gnt0   = Req0Valid_i && (!Req1Valid_i || !prefer1);
    assign gnt1   = Req1Valid_i && (!Req0Valid_i || prefer1);
    assign accept = (state_q == IDLE) && (Req0Valid_i || Req1Valid_i);

    // Only the owner's Ready can release RESP. Any other Ready is ignored.
    assign owner_rdy = owner_q ? Rsp1Ready_i : Rsp0Ready_i;

    // State register
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (owner_rdy) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Req0Ready_o = 1'b0;
        Req1Ready_o = 1'b0;
        Rsp0Valid_o = 1'b0;
        Rsp1Valid_o = 1'b0;
        Busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                Req0Ready_o = gnt0;
                Req1Ready_o = gnt1;
                Busy_o      = 1'b0;
            end
            RESP: begin
                Rsp0Valid_o = !owner_q;
                Rsp1Valid_o = owner_q;
            end
            default: ;
        endcase
    end

    // Operand and result registers. The control code passes through
    // undecoded. The Zero flag comes from the ALU; it is not computed here.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            owner_q  <= 1'b0;
            ctl_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= gnt1;
                ctl_q   <= gnt1 ? Req1Ctl_i : Req0Ctl_i;
                a_q     <= gnt1 ? Req1A_i   : Req0A_i;
                b_q     <= gnt1 ? Req1B_i   : Req0B_i;
            end
            if (state_q == EXEC) begin
                result_q <= ALUResult_i;
                zero_q   <= ALUZero_i;
            end
        end
    end

    assign ALUControl_o = ctl_q;
    assign ALUA_o       = a_q;
    assign ALUB_o       = b_q;
    assign RspResult_o  = result_q;
    assign RspZero_o    = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A small behavioural ALU sits on the ALU
//   side of the DUT. Every step samples 1 time unit after the rising edge.
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid, Req0Ready, Req1Ready;
    logic [3:0]  Req0Ctl, Req1Ctl;
    logic [31:0] Req0A, Req0B, Req1A, Req1B;
    logic        Rsp0Valid, Rsp1Valid, Rsp0Ready, Rsp1Ready;
    logic [31:0] RspResult;
    logic        RspZero;
    logic [3:0]  ALUControl;
    logic [31:0] ALUA, ALUB, ALUResult;
    logic        ALUZero;
    logic        Busy;

    int checks   = 0;
    int failures = 0;
    bit rr_build;
    bit exp0;

    always #5 Clk = ~Clk;

    alu_arbiter #(.CTL_W(4)) dut (
        .Clk_i        (Clk),
        .Reset_i      (Reset),
        .Req0Valid_i  (Req0Valid),
        .Req0Ready_o  (Req0Ready),
        .Req0Ctl_i    (Req0Ctl),
        .Req0A_i      (Req0A),
        .Req0B_i      (Req0B),
        .Req1Valid_i  (Req1Valid),
        .Req1Ready_o  (Req1Ready),
        .Req1Ctl_i    (Req1Ctl),
        .Req1A_i      (Req1A),
        .Req1B_i      (Req1B),
        .Rsp0Valid_o  (Rsp0Valid),
        .Rsp0Ready_i  (Rsp0Ready),
        .Rsp1Valid_o  (Rsp1Valid),
        .Rsp1Ready_i  (Rsp1Ready),
        .RspResult_o  (RspResult),
        .RspZero_o    (RspZero),
        .ALUControl_o (ALUControl),
        .ALUA_o       (ALUA),
        .ALUB_o       (ALUB),
        .ALUResult_i  (ALUResult),
        .ALUZero_i    (ALUZero),
        .Busy_o       (Busy)
    );

    // Behavioural ALU32Bit: unused codes return 0, code 14 returns all ones.
    always_comb begin
        ALUResult = 32'd0;
        case (ALUControl)
            4'd0:  ALUResult = ALUA & ALUB;
            4'd1:  ALUResult = ALUA | ALUB;
            4'd2:  ALUResult = ALUA + ALUB;
            4'd6:  ALUResult = ALUA - ALUB;
            4'd7:  ALUResult = ($signed(ALUA) < $signed(ALUB)) ? 32'd1 : 32'd0;
            4'd12: ALUResult = ~(ALUA | ALUB);
            4'd14: ALUResult = 32'hFFFF_FFFF;
            default: ALUResult = 32'd0;
        endcase
    end
    assign ALUZero = (ALUResult == 32'd0);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
`ifdef ALU_ARB_RR_EN
        rr_build = 1'b1;
`else
        rr_build = 1'b0;
`endif
        Reset = 1'b1;
        Req0Valid = 0; Req1Valid = 0; Rsp0Ready = 0; Rsp1Ready = 0;
        Req0Ctl = 0; Req1Ctl = 0; Req0A = 0; Req0B = 0; Req1A = 0; Req1B = 0;
        tick(); tick();
        check("rst_busy",    Busy,       0);
        check("rst_result",  RspResult,  0);
        check("rst_zero",    RspZero,    0);
        check("rst_rsp0v",   Rsp0Valid,  0);
        check("rst_aluctl",  ALUControl, 0);
        Reset = 1'b0;

        // Port 0 ADD 5+7. Then check that port 1's Ready is ignored.
        Req0Valid = 1; Req0Ctl = 4'd2; Req0A = 5; Req0B = 7;
        #1;
        check("t1_req0rdy_T",  Req0Ready, 1);
        check("t1_req1rdy_T",  Req1Ready, 0);
        tick();
        Req0Valid = 0;
        check("t1_exec_busy",  Busy,       1);
        check("t1_exec_rdy0",  Req0Ready,  0);
        check("t1_exec_rsp0v", Rsp0Valid,  0);
        check("t1_aluctl",     ALUControl, 2);
        check("t1_alua",       ALUA,       5);
        check("t1_alub",       ALUB,       7);
        tick();
        check("t1_rsp0v_T2",   Rsp0Valid,  1);
        check("t1_rsp1v_T2",   Rsp1Valid,  0);
        check("t1_result",     RspResult,  12);
        check("t1_zero",       RspZero,    0);
        Rsp1Ready = 1;
        tick();
        check("t1_nonowner_ign", Rsp0Valid, 1);
        Rsp1Ready = 0; Rsp0Ready = 1;
        tick();
        check("t1_done_busy",  Busy,      0);
        check("t1_done_rsp0v", Rsp0Valid, 0);
        Rsp0Ready = 0;

        // Port 1 SUB 9-9 -> 0, Zero=1. Rsp1Ready is held high the whole time
        // and must be ignored outside RESP.
        Req1Valid = 1; Req1Ctl = 4'd6; Req1A = 9; Req1B = 9; Rsp1Ready = 1;
        #1;
        check("t2_req1rdy",  Req1Ready, 1);
        check("t2_req0rdy",  Req0Ready, 0);
        tick();
        Req1Valid = 0;
        check("t2_exec_busy", Busy, 1);
        tick();
        check("t2_rsp1v",    Rsp1Valid, 1);
        check("t2_rsp0v",    Rsp0Valid, 0);
        check("t2_result",   RspResult, 0);
        check("t2_zero",     RspZero,   1);
        tick();
        check("t2_done_busy", Busy, 0);
        Rsp1Ready = 0;

        // Both ports are valid continuously. The pointer is back at port 0.
        Req0Valid = 1; Req0Ctl = 4'd2;  Req0A = 1;   Req0B = 2;
        Req1Valid = 1; Req1Ctl = 4'd14; Req1A = 100; Req1B = 200;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp0 = rr_build ? (i % 2 == 0) : 1'b1;
            check($sformatf("t3_g%0d_rdy0", i), Req0Ready, exp0);
            check($sformatf("t3_g%0d_rdy1", i), Req1Ready, !exp0);
            tick(); tick();
            check($sformatf("t3_g%0d_rsp0v", i), Rsp0Valid, exp0);
            check($sformatf("t3_g%0d_rsp1v", i), Rsp1Valid, !exp0);
            check($sformatf("t3_g%0d_res", i), RspResult, exp0 ? 32'd3 : 32'hFFFF_FFFF);
            if (exp0) Rsp0Ready = 1; else Rsp1Ready = 1;
            if (i == 3) begin Req0Valid = 0; Req1Valid = 0; end
            tick();
            Rsp0Ready = 0; Rsp1Ready = 0;
        end
        check("t3_end_busy", Busy, 0);

        // Port 0 AND. The response is held for 5 cycles while port 1 waits.
        Req0Valid = 1; Req0Ctl = 4'd0; Req0A = 32'hF0F0; Req0B = 32'hFF00;
        #1;
        tick();
        Req0Valid = 0;
        Req1Valid = 1; Req1Ctl = 4'd2; Req1A = 1; Req1B = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_c%0d_rsp0v", i), Rsp0Valid, 1);
            check($sformatf("t4_c%0d_res", i),   RspResult, 32'hF000);
            check($sformatf("t4_c%0d_busy", i),  Busy,      1);
            check($sformatf("t4_c%0d_rdy1", i),  Req1Ready, 0);
            tick();
        end
        Req1Valid = 0; Rsp0Ready = 1;
        tick();
        Rsp0Ready = 0;
        check("t4_done_busy", Busy, 0);

        // Reset during EXEC aborts the operation.
        Req0Valid = 1; Req0Ctl = 4'd15; Req0A = 3; Req0B = 4;
        #1;
        check("t5_req0rdy", Req0Ready, 1);
        tick();
        Req0Valid = 0;
        check("t5_exec_ctl", ALUControl, 15);
        Reset = 1;
        #1;
        check("t5_rst_busy",   Busy,       0);
        check("t5_rst_result", RspResult,  0);
        check("t5_rst_aluctl", ALUControl, 0);
        tick();
        Reset = 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_c%0d_rsp0v", i), Rsp0Valid, 0);
            check($sformatf("t5_c%0d_rsp1v", i), Rsp1Valid, 0);
            check($sformatf("t5_c%0d_busy", i),  Busy,      0);
            tick();
        end

        // After reset the pointer favours port 0. SLT 3<4 -> 1.
        Req0Valid = 1; Req0Ctl = 4'd7; Req0A = 3; Req0B = 4;
        Req1Valid = 1; Req1Ctl = 4'd2; Req1A = 8; Req1B = 8;
        #1;
        check("t6_rdy0", Req0Ready, 1);
        check("t6_rdy1", Req1Ready, 0);
        tick();
        Req0Valid = 0; Req1Valid = 0;
        tick();
        check("t6_rsp0v",  Rsp0Valid, 1);
        check("t6_result", RspResult, 1);
        check("t6_zero",   RspZero,   0);
        Rsp0Ready = 1;
        tick();
        Rsp0Ready = 0;
        check("t6_done_busy", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
